// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin one-hot arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NREQ     = 8;
  localparam int DEF_IDXW     = 3;
  localparam int DEF_MAX_HOLD = 16;
  localparam int HOLD_W       = 8;

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with an enable; output is all zeros when disabled.
module onehot_dec #(
  parameter int NREQ = 8,
  parameter int IDXW = 3
) (
  input  logic [IDXW-1:0] idx_i,
  input  logic            en_i,
  output logic [NREQ-1:0] onehot_o
);

  assign onehot_o = en_i ? (NREQ'(1) << idx_i) : '0;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered binary owner index and decoded one-hot grant.
// Optional hold-timeout is built when ARB_TIMEOUT_EN is defined.
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int IDXW     = DEF_IDXW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  if (NREQ != (1 << IDXW)) begin : g_bad_cfg
    $error("rr_onehot_arbiter: NREQ must equal 2**IDXW");
  end

  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            tmo_q, tmo_d;
  logic            rel, force_rel;

  // Search: rotate so bit 0 is the slot after the last owner, find lowest, un-rotate.
  logic [IDXW:0]     shift;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDXW-1:0]   off, pick;

  always_comb begin
    shift = (IDXW+1)'(idx_q) + (IDXW+1)'(1);
    dbl   = {req, req};
    rot   = dbl[shift +: NREQ];
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDXW'(k);
    end
    pick  = idx_q + IDXW'(1) + off;
  end

  assign rel = done | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign hold_d    = (state_q == GRANT) ? hold_q + HOLD_W'(1) : '0;
  assign force_rel = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1)) && !rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  localparam int UNUSED_MAX_HOLD = MAX_HOLD;
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = pick;
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        // A normal release wins over a forced one, so no pulse in that case.
        if (rel || force_rel) begin
          state_d = IDLE;
          valid_d = 1'b0;
          tmo_d   = force_rel;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDXW'(NREQ - 1);
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
    end
  end

  onehot_dec #(.NREQ(NREQ), .IDXW(IDXW)) u_dec (
    .idx_i    (idx_q),
    .en_i     (valid_q),
    .onehot_o (grant)
  );

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = tmo_q;

endmodule
